pixel_sequencer: RTL and testbench
==================================

# pixel_sequencer

Frame-level work generator that walks every sample of every pixel and issues `(x, y, s)` work items to `ray_gen`, the stage directly downstream. A `start` pulse launches one frame. The block emits one item per cycle under a valid/ready handshake, in sample-major order: sample innermost, then x, then y. It reports `frame_done` once the final item has been accepted. It is the entry point of the per-frame ray pipeline and replaces ad-hoc testbench/host driving of `ray_gen`.

## Interface
Parameters:
- `IMG_W`, default 640: pixels per row; must be ≤ 2^`PX_WIDTH`.
- `IMG_H`, default 480: rows per frame; must be ≤ 2^`PY_WIDTH`.
- `SPP`, default 4: samples per pixel; must be ≤ 2^`RPP_WIDTH`, ≥ 1.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: one-cycle frame launch request.
- `ready`  in  1: downstream can accept an item this cycle (credit/FIFO not full).
- `op_vld`  out  1: work item valid; connects to `ray_gen.op_vld` through the accept gate.
- `x`  out  `PX_WIDTH`: pixel column.
- `y`  out  `PY_WIDTH`: pixel row.
- `s`  out  `RPP_WIDTH`: sample index.
- `last_sample`  out  1: item is sample `SPP-1` of its pixel.
- `busy`  out  1: frame in progress.
- `frame_done`  out  1: one-cycle pulse after the final item is accepted.
- `stall_cnt`  out  32: cycles with `op_vld && !ready` in current/last frame (only when macro enabled, see Configuration).

## Operation
- FSM states IDLE, RUN, DONE.
- IDLE: `op_vld`=0. `start`=1 → RUN with counters (x, y, s) = (0, 0, 0) and `op_vld`=1 the next cycle.
- RUN: accept = `op_vld && ready`. On accept, advance:
  - s+1.
  - When s==`SPP-1`: s←0, x+1.
  - When also x==`IMG_W-1`: x←0, y+1.
- Final item (`IMG_W-1`, `IMG_H-1`, `SPP-1`) accepted → DONE, `op_vld`←0.
- DONE: `frame_done`=1 for exactly one cycle → IDLE.
- No accept: all outputs hold (x, y, s, `op_vld`, `last_sample` stable while stalled).
- `last_sample` = (s == `SPP-1`), registered alongside s.
- `busy` = 1 in RUN and DONE.
- `start` while busy is ignored. `start` in the DONE cycle is ignored. `start` in IDLE on the cycle after DONE is honoured.
- `ready` is sampled only while `op_vld`=1; its value in IDLE/DONE is irrelevant.
- The downstream gate is `ray_gen.op_vld = op_vld && ready`; the sequencer does not gate internally.

## Timing
- Reset (async assert, sync release): state IDLE; `op_vld`, x, y, s, `last_sample`, `busy`, `frame_done` = 0; `stall_cnt` = 0.
- Reset mid-frame aborts immediately. No `frame_done` is issued for the aborted frame.
- All outputs are registered; there is no combinational path from `ready` or `start` to any output.
- Latency: `start`@T → `op_vld`=1 with (0,0,0) @T+1.
- Throughput: 1 item/cycle with `ready` held high. A full frame takes `IMG_W*IMG_H*SPP` RUN cycles, and `frame_done` asserts on the cycle after the final accept.
- Counter wrap follows exactly the limits above. Counters never exceed limit-1, including the SPP=1 case, where s stays at 0 and `last_sample` stays at 1.

## Configuration
- `PIXEL_SEQ_STALL_CNT_EN` defined:
  - `stall_cnt` port present.
  - Clears to 0 on the `start` accept.
  - Increments on each RUN cycle with `op_vld && !ready`, saturating at 2^32-1.
  - Holds its value after the frame ends.
- Not defined: port and counter absent; behaviour otherwise identical.

## Structure
- Shared package `pathsy_pkg`:
  - `seq_state_t` enum (IDLE/RUN/DONE).
  - `work_item_t` struct {x, y, s, last_sample} using `PX_WIDTH`/`PY_WIDTH`/`RPP_WIDTH` from `defines.svh`.
  - Default frame constants `IMG_W_DEF`=640, `IMG_H_DEF`=480.
- One sub-module: `wrap_counter`, parameters LIMIT and WIDTH, with inputs inc and clr and outputs value and wrap. Instantiate three times, chained via wrap → inc.

## Test plan
- Reset/idle: `rst_n`=0 then release, no `start` → all outputs 0 for 20 cycles; `frame_done` never asserts.
- Full frame, `IMG_W`=3, `IMG_H`=2, `SPP`=2, `ready`=1:
  - `start`@T → exactly 12 accepts @T+1..T+12.
  - Order: (0,0,0), (0,0,1), (1,0,0) … (2,1,1); `last_sample` on odd s.
  - `frame_done` pulse @T+13; `busy` falls @T+14.
- Backpressure: same config, `ready` low on every third cycle → item sequence identical to the `ready`=1 run, outputs stable during stalls, 12 accepts total; `stall_cnt` equals the number of low-`ready` cycles with `op_vld`=1 (macro enabled).
- Start while busy: `start` pulsed mid-frame and on the DONE cycle → no restart, exactly 12 items, one `frame_done`; `start` the next cycle launches a new frame from (0,0,0).
- Reset mid-frame: `rst_n`=0 after the 5th accept → outputs 0 asynchronously, no `frame_done`; a subsequent `start` yields 12 items from (0,0,0).
- `SPP`=1, `IMG_W`=2, `IMG_H`=1 → items (0,0,0), (1,0,0), `last_sample`=1 on both, `frame_done` 1 cycle after the second accept.

Source files
------------

// File: rtl/pathsy_pkg.sv
// rtl/pathsy_pkg.sv - shared types, field widths and frame defaults for the ray pipeline front end
package pathsy_pkg;

   localparam int PX_WIDTH  = 10;
   localparam int PY_WIDTH  = 9;
   localparam int RPP_WIDTH = 4;

   localparam int IMG_W_DEF = 640;
   localparam int IMG_H_DEF = 480;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   typedef struct packed {
      logic [PX_WIDTH-1:0]  x;
      logic [PY_WIDTH-1:0]  y;
      logic [RPP_WIDTH-1:0] s;
      logic                 last_sample;
   } work_item_t;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-LIMIT counter; wrap flags the increment that returns it to zero
module wrap_counter #(
   parameter int LIMIT = 2,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] value,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(LIMIT - 1);

   logic [WIDTH-1:0] value_q, value_d;

   // Combinational so the next stage of the chain advances in the same cycle
   assign wrap  = inc && (value_q == MAX_VAL);
   assign value = value_q;

   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end else if (inc) begin
         value_d = wrap ? '0 : value_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

endmodule

// File: rtl/pixel_sequencer.sv
// rtl/pixel_sequencer.sv - frame walker issuing (x, y, s) work items; PIXEL_SEQ_STALL_CNT_EN adds stall_cnt
module pixel_sequencer
   import pathsy_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF,
   parameter int SPP   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 ready,
   output logic                 op_vld,
   output logic [PX_WIDTH-1:0]  x,
   output logic [PY_WIDTH-1:0]  y,
   output logic [RPP_WIDTH-1:0] s,
   output logic                 last_sample,
   output logic                 busy,
`ifdef PIXEL_SEQ_STALL_CNT_EN
   output logic [31:0]          stall_cnt,
`endif
   output logic                 frame_done
);

   localparam logic [RPP_WIDTH-1:0] S_PENULT = RPP_WIDTH'((SPP > 1) ? SPP - 2 : 0);

   seq_state_t           state_q, state_d;
   logic                 last_q, last_d;
   logic                 launch, accept;
   logic                 s_wrap, x_wrap, y_wrap;
   logic [PX_WIDTH-1:0]  x_val;
   logic [PY_WIDTH-1:0]  y_val;
   logic [RPP_WIDTH-1:0] s_val;
   work_item_t           item;

   assign launch = (state_q == IDLE) && start;
   assign accept = (state_q == RUN) && ready;

   wrap_counter #(.LIMIT(SPP), .WIDTH(RPP_WIDTH)) u_s_cnt (
      .clk(clk), .rst_n(rst_n), .inc(accept), .clr(launch), .value(s_val), .wrap(s_wrap)
   );
   wrap_counter #(.LIMIT(IMG_W), .WIDTH(PX_WIDTH)) u_x_cnt (
      .clk(clk), .rst_n(rst_n), .inc(s_wrap), .clr(launch), .value(x_val), .wrap(x_wrap)
   );
   wrap_counter #(.LIMIT(IMG_H), .WIDTH(PY_WIDTH)) u_y_cnt (
      .clk(clk), .rst_n(rst_n), .inc(x_wrap), .clr(launch), .value(y_val), .wrap(y_wrap)
   );

   // last_sample tracks the value s will hold after this cycle
   always_comb begin
      last_d = last_q;
      if (launch) begin
         last_d = (SPP == 1);
      end else if (accept) begin
         last_d = (SPP == 1) || (!s_wrap && (s_val == S_PENULT));
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (accept && y_wrap) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   assign item = '{x: x_val, y: y_val, s: s_val, last_sample: last_q};

   assign op_vld      = (state_q == RUN);
   assign busy        = (state_q != IDLE);
   assign frame_done  = (state_q == DONE);
   assign x           = item.x;
   assign y           = item.y;
   assign s           = item.s;
   assign last_sample = item.last_sample;

`ifdef PIXEL_SEQ_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (launch) begin
         stall_d = '0;
      end else if ((state_q == RUN) && !ready && (stall_q != '1)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pixel_sequencer.sv
// tb/tb_pixel_sequencer.sv - randomized self-checking bench for pixel_sequencer against a loop-nest frame model
module tb_pixel_sequencer;
   import pathsy_pkg::*;

   localparam int W = 3;
   localparam int H = 2;
   localparam int S = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic                 ready = 1'b0;
   logic                 op_vld, last_sample, busy, frame_done;
   logic [PX_WIDTH-1:0]  x;
   logic [PY_WIDTH-1:0]  y;
   logic [RPP_WIDTH-1:0] s;

   logic                 start1 = 1'b0;
   logic                 ready1 = 1'b1;
   logic                 op_vld1, last_sample1, busy1, frame_done1;
   logic [PX_WIDTH-1:0]  x1;
   logic [PY_WIDTH-1:0]  y1;
   logic [RPP_WIDTH-1:0] s1;

`ifdef PIXEL_SEQ_STALL_CNT_EN
   logic [31:0] stall_cnt, stall_cnt1;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pixel_sequencer #(.IMG_W(W), .IMG_H(H), .SPP(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
      .op_vld(op_vld), .x(x), .y(y), .s(s), .last_sample(last_sample),
      .busy(busy),
`ifdef PIXEL_SEQ_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .frame_done(frame_done)
   );

   pixel_sequencer #(.IMG_W(2), .IMG_H(1), .SPP(1)) u_dut_spp1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .ready(ready1),
      .op_vld(op_vld1), .x(x1), .y(y1), .s(s1), .last_sample(last_sample1),
      .busy(busy1),
`ifdef PIXEL_SEQ_STALL_CNT_EN
      .stall_cnt(stall_cnt1),
`endif
      .frame_done(frame_done1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [26:0] outs();
      return {op_vld, x, y, s, last_sample, busy, frame_done};
   endfunction

   function automatic logic [23:0] item_vec(input int ix, input int iy, input int is, input bit il);
      logic [PX_WIDTH-1:0]  vx = PX_WIDTH'(ix);
      logic [PY_WIDTH-1:0]  vy = PY_WIDTH'(iy);
      logic [RPP_WIDTH-1:0] vs = RPP_WIDTH'(is);
      return {vx, vy, vs, il};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: ready held high, 1: ready low every third cycle, 2: random ready
   task automatic run_frame(input int mode, input bit spam);
      logic [23:0] exp_q[$];
      int          acc = 0;
      int          stalls = 0;
      int          ndone = 0;
      int          last_acc = -1;
      int          done_cyc = -1;
      bit          prev_stall = 1'b0;
      bit          rdy;
      logic [26:0] prev = '0;

      for (int iy = 0; iy < H; iy++)
         for (int ix = 0; ix < W; ix++)
            for (int is = 0; is < S; is++)
               exp_q.push_back(item_vec(ix, iy, is, is == S - 1));

      start = 1'b1;
      tick();
      start = 1'b0;
      check("launch_vld", {63'd0, op_vld}, 64'd1);
      check("launch_item", {40'd0, x, y, s, last_sample}, {40'd0, item_vec(0, 0, 0, S == 1)});

      for (int cyc = 1; cyc < 200; cyc++) begin
         if (prev_stall) check("stall_hold", {37'd0, outs()}, {37'd0, prev});
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            start = 1'b0;
            check("busy_fall", {63'd0, busy}, 64'd0);
            check("done_pulse", {63'd0, frame_done}, 64'd0);
            break;
         end
         if (frame_done) begin
            ndone++;
            done_cyc = cyc;
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3 != 2);
            default: rdy = ($urandom_range(0, 3) != 0);
         endcase
         ready = rdy;
         start = spam && (cyc == 5 || frame_done);
         if (op_vld && rdy) begin
            acc++;
            last_acc = cyc;
            if (exp_q.size() == 0) check("extra_item", {40'd0, x, y, s, last_sample}, 64'd0);
            else check("item", {40'd0, x, y, s, last_sample}, {40'd0, exp_q.pop_front()});
         end
         if (op_vld && !rdy) stalls++;
         prev_stall = op_vld && !rdy;
         prev = outs();
         tick();
      end
      start = 1'b0;
      ready = 1'b0;

      check("accepts", 64'(acc), 64'(W * H * S));
      check("done_count", 64'(ndone), 64'd1);
      check("done_latency", 64'(done_cyc), 64'(last_acc + 1));
      if (mode == 0) check("done_cycle", 64'(done_cyc), 64'(W * H * S + 1));
`ifdef PIXEL_SEQ_STALL_CNT_EN
      check("stall_cnt", {32'd0, stall_cnt}, 64'(stalls));
`endif
   endtask

   task automatic reset_mid_frame();
      int acc = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      ready = 1'b1;
      for (int cyc = 0; cyc < 50 && acc < 5; cyc++) begin
         if (op_vld) acc++;
         tick();
      end
      check("pre_reset_accepts", 64'(acc), 64'd5);
      rst_n = 1'b0;
      #1;
      check("async_reset_outs", {37'd0, outs()}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_hold", {37'd0, outs()}, 64'd0);
      end
      rst_n = 1'b1;
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("after_abort_idle", {37'd0, outs()}, 64'd0);
      end
   endtask

   task automatic spp1_frame();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("spp1_item0", {39'd0, op_vld1, x1, y1, s1, last_sample1}, {39'd0, 1'b1, item_vec(0, 0, 0, 1'b1)});
      tick();
      check("spp1_item1", {39'd0, op_vld1, x1, y1, s1, last_sample1}, {39'd0, 1'b1, item_vec(1, 0, 0, 1'b1)});
      tick();
      check("spp1_done", {62'd0, frame_done1, op_vld1}, 64'd2);
      tick();
      check("spp1_idle", {62'd0, busy1, frame_done1}, 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         ready = 1'($urandom_range(0, 1));
         tick();
         check("idle_outs", {37'd0, outs()}, 64'd0);
      end
      ready = 1'b0;
`ifdef PIXEL_SEQ_STALL_CNT_EN
      check("stall_cnt_reset", {32'd0, stall_cnt}, 64'd0);
`endif

      run_frame(0, 1'b0);
      run_frame(1, 1'b0);
      run_frame(0, 1'b1);
      run_frame(0, 1'b0);
      reset_mid_frame();
      run_frame(0, 1'b0);
      for (int i = 0; i < 4; i++) run_frame(2, 1'b0);
      spp1_frame();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
